// File: rtl/mem_1rwm_pkg.sv
// Shared constants and helpers for the mem_1rwm single-port byte-masked RAM.
package mem_1rwm_pkg;

    localparam int BYTE_W = 8;

    function automatic int lanes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_1rwm_if.sv
// Bus bundle for mem_1rwm: one read-or-write port with a byte-lane write mask.
interface mem_1rwm_if
    import mem_1rwm_pkg::*;
#(
    parameter int ELEMENTS_W = 10,
    parameter int WIDTH      = 32
);

    logic [ELEMENTS_W-1:0]    address;
    logic                     read;
    logic [WIDTH-1:0]         readdata;
    logic                     write;
    logic [lanes(WIDTH)-1:0]  writeenable;
    logic [WIDTH-1:0]         writedata;

    modport master (
        output address,
        output read,
        input  readdata,
        output write,
        output writeenable,
        output writedata
    );

    modport slave (
        input  address,
        input  read,
        output readdata,
        input  write,
        input  writeenable,
        input  writedata
    );

endinterface

// File: rtl/mem_1rwm_lane.sv
// One byte-wide slice of mem_1rwm: 2**ELEMENTS_W x 8 RAM with a registered, held read byte.
module mem_1rwm_lane
    import mem_1rwm_pkg::*;
#(
    parameter int ELEMENTS_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ELEMENTS_W-1:0] address,
    input  logic                  read,
    input  logic                  write_en,
    input  logic [BYTE_W-1:0]     wdata,
    output logic [BYTE_W-1:0]     rdata
);

    localparam int DEPTH = 2 ** ELEMENTS_W;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rd_byte_p1;

    // Array is never reset so the tools can map it onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && write_en) begin
            mem[address] <= wdata;
        end
    end

    // p0 -> p1: read register samples the pre-write word (read-first) and holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_byte_p1 <= '0;
        end else if (read) begin
            rd_byte_p1 <= mem[address];
        end
    end

    assign rdata = rd_byte_p1;

endmodule

// File: rtl/mem_1rwm.sv
// Single-port synchronous RAM with byte write mask and one-cycle registered, held read data.
// Optional simulation checks on X-valued controls are enabled by defining MEM_1RWM_ASSERT_EN.
module mem_1rwm
    import mem_1rwm_pkg::*;
#(
    parameter int ELEMENTS_W = 10,
    parameter int WIDTH      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_1rwm_if.slave     bus
);

    localparam int LANES = lanes(WIDTH);

    logic [WIDTH-1:0] rdata;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_1rwm_lane #(
            .ELEMENTS_W (ELEMENTS_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .address  (bus.address),
            .read     (bus.read),
            .write_en (bus.write & bus.writeenable[i]),
            .wdata    (bus.writedata[i*BYTE_W +: BYTE_W]),
            .rdata    (rdata[i*BYTE_W +: BYTE_W])
        );
    end

    assign bus.readdata = rdata;

`ifdef MEM_1RWM_ASSERT_EN
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if ($isunknown(bus.read) || $isunknown(bus.write)) begin
                $error("mem_1rwm: read/write strobe is X out of reset");
            end else begin
                if ((bus.read || bus.write) && $isunknown(bus.address)) begin
                    $error("mem_1rwm: address is X during access");
                end
                if (bus.write && $isunknown(bus.writeenable)) begin
                    $error("mem_1rwm: writeenable is X during write");
                end
            end
        end
    end
`else
    // Checks compiled out; the synthesizable logic above is unchanged.
`endif

endmodule

// File: tb/tb_mem_1rwm.sv
// Directed bench for mem_1rwm: reset, full/masked writes, hold, read-first and full address sweep.
module tb_mem_1rwm;

    localparam int ELEMENTS_W = 10;
    localparam int WIDTH      = 32;
    localparam int DEPTH      = 2 ** ELEMENTS_W;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_1rwm_if #(.ELEMENTS_W(ELEMENTS_W), .WIDTH(WIDTH)) bus ();

    mem_1rwm #(
        .ELEMENTS_W (ELEMENTS_W),
        .WIDTH      (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.writeenable = '0;
    endtask

    task automatic do_write(input logic [ELEMENTS_W-1:0] a, input logic [WIDTH-1:0] d, input logic [3:0] we);
        bus.address     = a;
        bus.writedata   = d;
        bus.writeenable = we;
        bus.write       = 1'b1;
        bus.read        = 1'b0;
        step();
        idle();
    endtask

    task automatic do_read(input logic [ELEMENTS_W-1:0] a);
        bus.address = a;
        bus.read    = 1'b1;
        bus.write   = 1'b0;
        step();
        idle();
    endtask

    initial begin
        logic [WIDTH-1:0] exp_w;
        total = 0;
        bad   = 0;

        // Reset with read held high: readdata must be cleared.
        rst_n           = 1'b0;
        bus.address     = '0;
        bus.read        = 1'b1;
        bus.write       = 1'b0;
        bus.writeenable = '0;
        bus.writedata   = '0;
        step();
        step();
        check("reset_readdata", bus.readdata, 32'h0);
        rst_n    = 1'b1;
        bus.read = 1'b0;
        step();
        step();
        check("post_reset_hold", bus.readdata, 32'h0);

        // Full-word write then read.
        do_write(10'd5, 32'hDEADBEEF, 4'hF);
        do_read(10'd5);
        check("full_write", bus.readdata, 32'hDEADBEEF);

        // Lanes 0 and 2 only.
        do_write(10'd5, 32'h11223344, 4'b0101);
        do_read(10'd5);
        check("byte_mask", bus.readdata, 32'hDE22BE44);

        // Empty mask changes nothing.
        do_write(10'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(10'd5);
        check("empty_mask", bus.readdata, 32'hDE22BE44);

        // Hold with read low while address and writedata toggle.
        for (int k = 0; k < 10; k++) begin
            bus.address   = ELEMENTS_W'($urandom);
            bus.writedata = $urandom;
            step();
            check($sformatf("hold_%0d", k), bus.readdata, 32'hDE22BE44);
        end

        // Read-first on simultaneous read and write.
        do_write(10'd7, 32'hA5A5A5A5, 4'hF);
        bus.address     = 10'd7;
        bus.writedata   = 32'h0;
        bus.writeenable = 4'hF;
        bus.write       = 1'b1;
        bus.read        = 1'b1;
        step();
        idle();
        check("read_first_old", bus.readdata, 32'hA5A5A5A5);
        do_read(10'd7);
        check("read_first_new", bus.readdata, 32'h00000000);

        // Reads and writes are ignored while in reset.
        do_write(10'd9, 32'h12345678, 4'hF);
        do_read(10'd9);
        check("pre_reset_word", bus.readdata, 32'h12345678);
        rst_n           = 1'b0;
        bus.address     = 10'd9;
        bus.writedata   = 32'h0;
        bus.writeenable = 4'hF;
        bus.write       = 1'b1;
        bus.read        = 1'b1;
        step();
        idle();
        check("reset_clears_read", bus.readdata, 32'h0);
        rst_n = 1'b1;
        do_read(10'd9);
        check("reset_blocks_write", bus.readdata, 32'h12345678);

        // Sweep: fill every word, read back in reverse.
        for (int i = 0; i < DEPTH; i++) begin
            do_write(ELEMENTS_W'(i), 32'(i) * 32'h01010101, 4'hF);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            exp_w = 32'(i) * 32'h01010101;
            do_read(ELEMENTS_W'(i));
            check($sformatf("sweep_%0d", i), bus.readdata, exp_w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
